lc3b_fetch_stage: RTL and testbench
===================================

Name: lc3b_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined LC-3b.
- Owns the PC and issues reads to instruction memory.
- Captures each returned instruction into the IF/ID pipeline register, which feeds the decode-stage control ROM (opcode, bits 4/5/11) and the rest of decode.
- Honours a downstream stall and a late-stage branch redirect/flush.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; first fetch address.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall_in  in  1  decode cannot accept; IF/ID must hold
br_taken  in  1  branch resolved taken this cycle; redirect and flush
br_target  in  16  redirect PC, valid when br_taken
imem_read  out  1  instruction read request
imem_address  out  16  instruction read address
imem_resp  in  1  read complete this cycle
imem_rdata  in  16  instruction word, valid when imem_resp
if_valid  out  1  IF/ID holds a real instruction
if_pc  out  16  incremented PC (fetch address + 2) of the IF/ID instruction
if_ir  out  16  IF/ID instruction word
if_opcode  out  4  if_ir[15:12]
if_bits4_5_11  out  3  {if_ir[11], if_ir[5], if_ir[4]}

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=FETCH, if_valid=0, if_ir=0, if_pc=0, buffer empty, saved target=0. imem_read=0 while rst=1.
- imem_read=1 in FETCH and DISCARD; imem_address=pc. Address must stay stable while imem_read=1 until imem_resp.
- IF/ID "load enable" = !stall_in || !if_valid. A bubble never blocks.
- FETCH, imem_resp=1, br_taken=0:
  - Load enable: if_ir<=rdata, if_pc<=pc+2, if_valid<=1, pc<=pc+2, stay FETCH.
  - Otherwise: buffer<=rdata, buffer_pc<=pc+2, pc<=pc+2, go HOLD.
- FETCH, br_taken=1, imem_resp=1: discard rdata, pc<=br_target, if_valid<=0, stay FETCH.
- FETCH, br_taken=1, imem_resp=0: saved_target<=br_target, if_valid<=0, go DISCARD. pc is unchanged, so the address stays stable.
- DISCARD:
  - Wait for imem_resp, then drop rdata, pc<=saved_target, go FETCH.
  - A further br_taken in DISCARD overwrites saved_target (latest wins) and holds if_valid=0.
  - If br_taken coincides with imem_resp, pc<=br_target.
- HOLD:
  - imem_read=0.
  - When stall_in=0: IF/ID<=buffer, if_valid<=1, go FETCH.
  - br_taken: drop buffer, pc<=br_target, if_valid<=0, go FETCH.
- Flush has priority over stall: br_taken clears if_valid even when stall_in=1.
- Simultaneous br_taken and load enable: nothing loads; if_valid=0.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 -> 16'h0000. Bit 0 is carried as given; no alignment trap.
- Throughput: one instruction per imem_resp. With a single-cycle response, one instruction per cycle.
- Reset mid-read: the outstanding request is abandoned. Memory must tolerate imem_read dropping.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32 bits) and perf_flushed (32 bits). Both reset to 0 and wrap.
  - perf_fetched increments on each IF/ID load with if_valid<=1.
  - perf_flushed increments each cycle br_taken=1 while if_valid=1 or buffer/read is discarded.
- Undefined: ports and counters absent. Behaviour otherwise identical.

Decomposition:
- lc3b_types package: lc3b_word (16-bit), lc3b_opcode (reuse), new enum lc3b_fetch_state {FETCH, HOLD, DISCARD}, constant lc3b_pc_incr=16'd2.
- One sub-module, lc3b_if_id_reg: holds valid/pc/ir, with load and flush inputs and async reset.

Test Plan:
1. Single-cycle memory, no stall, program at 0x0000: imem_address 0,2,4,6 on successive cycles. if_ir tracks rdata one cycle later; if_pc=2,4,6; if_opcode=ir[15:12].
2. stall_in=1 for 3 cycles with if_valid=1 and a response pending: the response goes to HOLD, imem_read=0, and if_ir is unchanged. On stall release the buffered word appears next cycle with no fetch lost or duplicated.
3. br_taken with br_target=0x0040 while imem_resp is 4 cycles away: imem_address holds the old PC until resp, the returned word is dropped, the next address is 0x0040, and if_valid=0 throughout.
4. br_taken in HOLD with stall_in=1: buffer dropped, if_valid=0, next imem_address=br_target.
5. pc=0xFFFE fetch: next imem_address=0x0000, if_pc=0x0000.
6. rst asserted mid-read (async, between edges): if_valid=0 and imem_read=0 immediately. After release, imem_address=RESET_PC.

Source files
------------

// File: rtl/lc3b_fetch_stage_pkg.sv
// Shared LC-3b types for the fetch stage: word/opcode types, fetch FSM states, PC step.
// Optional FETCH_PERF_CNT_EN (used in the top) adds fetch/flush performance counters.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } lc3b_fetch_state;

    localparam lc3b_word lc3b_pc_incr = 16'd2;

endpackage

// File: rtl/lc3b_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: valid/pc/ir with load and flush (flush wins).
module lc3b_if_id_reg
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load_i,
    input  logic     flush_i,
    input  lc3b_word pc_i,
    input  lc3b_word ir_i,
    output logic     valid_o,
    output lc3b_word pc_o,
    output lc3b_word ir_o
);

    logic     valid_q;
    lc3b_word pc_q;
    lc3b_word ir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ir_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            ir_q    <= ir_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign ir_o    = ir_q;

endmodule

// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction fetch: owns the PC, reads imem, fills IF/ID; honours stall and branch flush.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_flushed counter outputs.
//
// state   | meaning
// FETCH   | read outstanding at pc; response goes to IF/ID or to the skid buffer
// HOLD    | IF/ID stalled and full, one word parked in the buffer; no read
// DISCARD | branch hit mid-read; finish the old read, drop it, then jump
module lc3b_fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        br_taken,
    input  lc3b_word    br_target,
    output logic        imem_read,
    output lc3b_word    imem_address,
    input  logic        imem_resp,
    input  lc3b_word    imem_rdata,
    output logic        if_valid,
    output lc3b_word    if_pc,
    output lc3b_word    if_ir,
    output logic [3:0]  if_opcode,
    output logic [2:0]  if_bits4_5_11
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    lc3b_fetch_state state_q;
    lc3b_word        pc_q;
    lc3b_word        buf_ir_q;
    lc3b_word        buf_pc_q;
    lc3b_word        saved_target_q;

    lc3b_word pc_inc;
    logic     load_en;
    logic     have_new;
    lc3b_word new_pc;
    lc3b_word new_ir;
    logic     ifid_load;
    logic     ifid_flush;

    assign pc_inc  = pc_q + lc3b_pc_incr;
    assign load_en = !stall_in || !if_valid;

    always_comb begin
        have_new = 1'b0;
        new_pc   = pc_inc;
        new_ir   = imem_rdata;
        case (state_q)
            FETCH: have_new = imem_resp;
            HOLD: begin
                have_new = 1'b1;
                new_pc   = buf_pc_q;
                new_ir   = buf_ir_q;
            end
            default: have_new = 1'b0;
        endcase
    end

    // A consumed instruction with nothing behind it leaves a bubble.
    assign ifid_load  = load_en && have_new && !br_taken;
    assign ifid_flush = br_taken || (load_en && !have_new);

    assign imem_read    = !rst && (state_q != HOLD);
    assign imem_address = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            buf_ir_q       <= '0;
            buf_pc_q       <= '0;
            saved_target_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (br_taken) begin
                        if (imem_resp) begin
                            pc_q <= br_target;
                        end else begin
                            saved_target_q <= br_target;
                            state_q        <= DISCARD;
                        end
                    end else if (imem_resp) begin
                        pc_q <= pc_inc;
                        if (!load_en) begin
                            buf_ir_q <= imem_rdata;
                            buf_pc_q <= pc_inc;
                            state_q  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        pc_q    <= br_target;
                        state_q <= FETCH;
                    end else if (!stall_in) begin
                        state_q <= FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_resp) begin
                        pc_q    <= br_taken ? br_target : saved_target_q;
                        state_q <= FETCH;
                    end else if (br_taken) begin
                        saved_target_q <= br_target;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    lc3b_if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (new_pc),
        .ir_i    (new_ir),
        .valid_o (if_valid),
        .pc_o    (if_pc),
        .ir_o    (if_ir)
    );

    assign if_opcode     = if_ir[15:12];
    assign if_bits4_5_11 = {if_ir[11], if_ir[5], if_ir[4]};

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    // Every state has something to throw away on a branch: a read, a buffer or IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (ifid_load)
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if (br_taken && (if_valid || state_q == HOLD || imem_read))
                perf_flushed_q <= perf_flushed_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Self-checking bench for lc3b_fetch_stage: vector table, directed corner cases, random vs queue model.
module tb_lc3b_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = '0;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_ir;
    logic [3:0]  if_opcode;
    logic [2:0]  if_bits4_5_11;

    lc3b_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .imem_read     (imem_read),
        .imem_address  (imem_address),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_ir         (if_ir),
        .if_opcode     (if_opcode),
        .if_bits4_5_11 (if_bits4_5_11)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: instructions fetched but not yet consumed, oldest first (front = IF/ID contents).
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    bit          m_disc;
    logic [15:0] m_saved;

    function automatic bit m_read();
        return m_disc || (mq.size() < 2);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = RESET_PC;
        m_disc  = 0;
        m_saved = '0;
    endtask

    task automatic model_check();
        bit rd;
        rd = m_read();
        chk("m_read", {31'd0, imem_read}, {31'd0, rd});
        if (rd) chk("m_addr", {16'd0, imem_address}, {16'd0, m_pc});
        chk("m_valid", {31'd0, if_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk("m_ir", {16'd0, if_ir}, {16'd0, mq[0].ir});
            chk("m_pc", {16'd0, if_pc}, {16'd0, mq[0].pc});
            chk("m_opc", {28'd0, if_opcode}, {28'd0, mq[0].ir[15:12]});
            chk("m_bits", {29'd0, if_bits4_5_11}, {29'd0, mq[0].ir[11], mq[0].ir[5], mq[0].ir[4]});
        end
    endtask

    task automatic model_edge(input bit st, input bit br, input logic [15:0] tgt,
                              input bit rsp, input logic [15:0] rd);
        bit rdq;
        rdq = m_read();
        if (br) begin
            if (m_disc) begin
                m_saved = tgt;
                if (rsp) begin
                    m_pc   = tgt;
                    m_disc = 0;
                end
            end else if (rdq && !rsp) begin
                m_disc  = 1;
                m_saved = tgt;
            end else begin
                m_pc = tgt;
            end
            mq.delete();
        end else if (m_disc) begin
            if (rsp) begin
                m_pc   = m_saved;
                m_disc = 0;
            end
        end else begin
            if (!st && mq.size() > 0) void'(mq.pop_front());
            if (rdq && rsp) begin
                mq.push_back('{pc: m_pc + 16'd2, ir: rd});
                m_pc = m_pc + 16'd2;
            end
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit st, input bit br, input logic [15:0] tgt,
                        input bit rsp, input logic [15:0] rd);
        model_check();
        stall_in   = st;
        br_taken   = br;
        br_target  = tgt;
        imem_resp  = rsp;
        imem_rdata = rd;
        @(posedge clk);
        model_edge(st, br, tgt, rsp, rd);
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        resp;
        logic [15:0] rdata;
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // expected values are the outputs seen before the vector's clock edge
        tbl[0] = '{1'b0, 1'b1, 16'h1234, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 16'h5A6B, 1'b1, 16'h0002, 1'b1, 16'h1234, 16'h0002};
        tbl[2] = '{1'b0, 1'b1, 16'hF0F1, 1'b1, 16'h0004, 1'b1, 16'h5A6B, 16'h0004};
        tbl[3] = '{1'b1, 1'b1, 16'h0C30, 1'b1, 16'h0006, 1'b1, 16'hF0F1, 16'h0006};
        tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hF0F1, 16'h0006};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hF0F1, 16'h0006};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hF0F1, 16'h0006};
        tbl[7] = '{1'b0, 1'b1, 16'h2222, 1'b1, 16'h0008, 1'b1, 16'h0C30, 16'h0008};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b1, 16'h2222, 16'h000A};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b0, 16'h0000, 16'h0000};

        model_reset();
        #3;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_ir", {16'd0, if_ir}, 32'd0);
        chk("rst_pc", {16'd0, if_pc}, 32'd0);
        chk("rst_read", {31'd0, imem_read}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // single-cycle memory stream, then a 3-cycle stall into the skid buffer
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl%0d_read", i), {31'd0, imem_read}, {31'd0, tbl[i].e_read});
            if (tbl[i].e_read) chk($sformatf("tbl%0d_addr", i), {16'd0, imem_address}, {16'd0, tbl[i].e_addr});
            chk($sformatf("tbl%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_ir", i), {16'd0, if_ir}, {16'd0, tbl[i].e_ir});
                chk($sformatf("tbl%0d_pc", i), {16'd0, if_pc}, {16'd0, tbl[i].e_pc});
                chk($sformatf("tbl%0d_opc", i), {28'd0, if_opcode}, {28'd0, tbl[i].e_ir[15:12]});
            end
            step(tbl[i].stall, 1'b0, 16'h0000, tbl[i].resp, tbl[i].rdata);
        end

        // branch while the read is 4 cycles from completing
        step(0, 0, 16'h0000, 1, 16'h3333);
        step(0, 1, 16'h0040, 0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            chk("disc_addr", {16'd0, imem_address}, 32'h000C);
            chk("disc_valid", {31'd0, if_valid}, 32'd0);
            step(0, 0, 16'h0000, 0, 16'h0000);
        end
        chk("disc_addr_last", {16'd0, imem_address}, 32'h000C);
        step(0, 0, 16'h0000, 1, 16'hDEAD);
        chk("redir_addr", {16'd0, imem_address}, 32'h0040);
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 16'h0000, 1, 16'h1111);
        chk("redir_ir", {16'd0, if_ir}, 32'h1111);
        chk("redir_pc", {16'd0, if_pc}, 32'h0042);

        // branch while parked in HOLD with stall asserted
        step(1, 0, 16'h0000, 1, 16'hAAAA);
        chk("hold_read", {31'd0, imem_read}, 32'd0);
        step(1, 1, 16'h0100, 0, 16'h0000);
        chk("hold_br_valid", {31'd0, if_valid}, 32'd0);
        chk("hold_br_read", {31'd0, imem_read}, 32'd1);
        chk("hold_br_addr", {16'd0, imem_address}, 32'h0100);

        // repeated branches during a discard: latest target wins, coincident branch wins
        step(0, 1, 16'h0200, 0, 16'h0000);
        step(0, 1, 16'h0300, 0, 16'h0000);
        step(0, 0, 16'h0000, 1, 16'hBEEF);
        chk("latest_tgt", {16'd0, imem_address}, 32'h0300);
        step(0, 1, 16'h0400, 0, 16'h0000);
        step(0, 1, 16'h0500, 1, 16'hBEEF);
        chk("coinc_tgt", {16'd0, imem_address}, 32'h0500);

        // PC wrap
        step(0, 1, 16'hFFFE, 1, 16'h0000);
        chk("wrap_pre", {16'd0, imem_address}, 32'hFFFE);
        step(0, 0, 16'h0000, 1, 16'h7777);
        chk("wrap_addr", {16'd0, imem_address}, 32'h0000);
        chk("wrap_ifpc", {16'd0, if_pc}, 32'h0000);
        chk("wrap_ir", {16'd0, if_ir}, 32'h7777);

        // asynchronous reset between edges with a read outstanding
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_read", {31'd0, imem_read}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_addr", {16'd0, imem_address}, {16'd0, RESET_PC});
        chk("arst_rd1", {31'd0, imem_read}, 32'd1);

        // random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            bit          st;
            bit          br;
            bit          rsp;
            logic [15:0] tgt;
            logic [15:0] rd;
            st  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 11) == 0);
            tgt = 16'($urandom);
            rsp = m_read() && ($urandom_range(0, 2) != 0);
            rd  = 16'($urandom);
            step(st, br, tgt, rsp, rd);
        end
        model_check();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
